mips_bus_arbiter: RTL and testbench

- Shares the single external memory bus (address/read/write/writedata/byteenable/readdata/waitrequest) of mips_cpu_bus between the CPU's instruction-fetch port (I) and load/store port (D).
- Latches one master's request and runs it on the bus while honouring waitrequest.
- Returns a one-cycle completion pulse to that master.
- Sits inside mips_cpu_bus, between the core and the bus pins.

---
 rtl/mips_bus_arbiter.sv | 250 +++++++++++++++++++++++++
 tb/tb_mips_bus_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mips_bus_arbiter
//
// Shares the single external memory bus of mips_cpu_bus between the CPU's
// instruction-fetch master (I) and load/store master (D). One request is
// latched at a time, run on the bus while honouring waitrequest, and finished
// with a one-cycle completion pulse (waitrequest=0) back to the owning master.
//
// Ports
//   clk, reset        system clock, asynchronous active-low reset
//   i_read/i_address  fetch request from the core
//   i_readdata        fetched word, valid in the i_waitrequest=0 cycle
//   i_waitrequest     low for exactly one cycle when a fetch completes
//   d_read/d_write    load/store request (both high executes as a write)
//   d_address/d_writedata/d_byteenable   load/store request payload
//   d_readdata        load word, valid in the d_waitrequest=0 cycle
//   d_waitrequest     low for exactly one cycle when a load/store completes
//   address/read/write/writedata/byteenable  bus request outputs
//   readdata          bus read data, one cycle after an accepted read
//   waitrequest       bus stall
//   grant             01 = I owns the bus, 10 = D owns the bus, 00 = idle
//
// Parameters
//   ADDR_WIDTH, DATA_WIDTH  port widths
//   ROUND_ROBIN             1 = alternate on contention, 0 = D always wins
// -----------------------------------------------------------------------------
module mips_bus_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int ROUND_ROBIN = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    // instruction-fetch master
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic [DATA_WIDTH-1:0] i_readdata,
    output logic                  i_waitrequest,
    // load/store master
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [DATA_WIDTH-1:0] d_writedata,
    input  logic [3:0]            d_byteenable,
    output logic [DATA_WIDTH-1:0] d_readdata,
    output logic                  d_waitrequest,
    // external bus
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  read,
    output logic                  write,
    output logic [DATA_WIDTH-1:0] writedata,
    output logic [3:0]            byteenable,
    input  logic [DATA_WIDTH-1:0] readdata,
    input  logic                  waitrequest,
    // ownership indication
    output logic [1:0]            grant
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_RDATA = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_I    = 2'b01;
    localparam logic [1:0] GRANT_D    = 2'b10;
    localparam logic       RR_EN      = (ROUND_ROBIN != 0) ? 1'b1 : 1'b0;

    // registered state
    state_t                r_state;
    logic                  r_last_d;       // 1 = D held the bus last, 0 = I
    logic [1:0]            r_grant;
    logic [ADDR_WIDTH-1:0] r_address;
    logic                  r_read;
    logic                  r_write;
    logic [DATA_WIDTH-1:0] r_writedata;
    logic [3:0]            r_byteenable;
    logic [DATA_WIDTH-1:0] r_i_readdata;
    logic [DATA_WIDTH-1:0] r_d_readdata;
    logic                  r_i_wait;
    logic                  r_d_wait;

    // next-state values
    state_t                w_state_nxt;
    logic                  w_last_d_nxt;
    logic [1:0]            w_grant_nxt;
    logic [ADDR_WIDTH-1:0] w_address_nxt;
    logic                  w_read_nxt;
    logic                  w_write_nxt;
    logic [DATA_WIDTH-1:0] w_writedata_nxt;
    logic [3:0]            w_byteenable_nxt;
    logic [DATA_WIDTH-1:0] w_i_readdata_nxt;
    logic [DATA_WIDTH-1:0] w_d_readdata_nxt;
    logic                  w_i_wait_nxt;
    logic                  w_d_wait_nxt;

    // arbitration
    logic                  w_i_req;
    logic                  w_d_req;
    logic                  w_pick_d;

    assign w_i_req = i_read;
    assign w_d_req = d_read | d_write;

    // Winner selection: uncontended requests win outright; on contention the
    // round-robin mode hands the bus to whichever master did not own it last.
    always_comb begin
        w_pick_d = 1'b0;
        if (!(w_i_req && w_d_req)) begin
            w_pick_d = w_d_req;
        end else if (RR_EN) begin
            w_pick_d = ~r_last_d;
        end else begin
            w_pick_d = 1'b1;
        end
    end

    // Transaction FSM: next state, latched request and completion outputs.
    always_comb begin
        w_state_nxt      = r_state;
        w_last_d_nxt     = r_last_d;
        w_grant_nxt      = r_grant;
        w_address_nxt    = r_address;
        w_read_nxt       = r_read;
        w_write_nxt      = r_write;
        w_writedata_nxt  = r_writedata;
        w_byteenable_nxt = r_byteenable;
        w_i_readdata_nxt = r_i_readdata;
        w_d_readdata_nxt = r_d_readdata;
        // completion pulses are raised only on the transition into DONE
        w_i_wait_nxt     = 1'b1;
        w_d_wait_nxt     = 1'b1;

        case (r_state)
            ST_IDLE: begin
                if (w_i_req || w_d_req) begin
                    w_state_nxt = ST_ISSUE;
                    if (w_pick_d) begin
                        w_grant_nxt      = GRANT_D;
                        w_address_nxt    = d_address;
                        w_writedata_nxt  = d_writedata;
                        w_byteenable_nxt = d_byteenable;
                        // read+write together is executed as a write
                        w_write_nxt      = d_write;
                        w_read_nxt       = ~d_write;
                    end else begin
                        w_grant_nxt      = GRANT_I;
                        w_address_nxt    = i_address;
                        w_byteenable_nxt = 4'b1111;
                        w_write_nxt      = 1'b0;
                        w_read_nxt       = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_ISSUE: begin
                // every bus output holds its value while the bus stalls
                if (!waitrequest) begin
                    w_read_nxt  = 1'b0;
                    w_write_nxt = 1'b0;
                    if (r_write) begin
                        w_state_nxt = ST_DONE;
                        if (r_grant == GRANT_D) begin
                            w_d_wait_nxt = 1'b0;
                        end else begin
                            w_i_wait_nxt = 1'b0;
                        end
                    end else begin
                        w_state_nxt = ST_RDATA;
                    end
                end else begin
                    w_state_nxt = ST_ISSUE;
                end
            end

            ST_RDATA: begin
                // readdata is valid now; it goes straight to the owner's
                // output register so it appears together with the pulse
                w_state_nxt = ST_DONE;
                if (r_grant == GRANT_D) begin
                    w_d_readdata_nxt = readdata;
                    w_d_wait_nxt     = 1'b0;
                end else begin
                    w_i_readdata_nxt = readdata;
                    w_i_wait_nxt     = 1'b0;
                end
            end

            ST_DONE: begin
                w_state_nxt  = ST_IDLE;
                w_last_d_nxt = (r_grant == GRANT_D);
                w_grant_nxt  = GRANT_NONE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_read_nxt  = 1'b0;
                w_write_nxt = 1'b0;
                w_grant_nxt = GRANT_NONE;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_last_d     <= 1'b0;
            r_grant      <= GRANT_NONE;
            r_address    <= {ADDR_WIDTH{1'b0}};
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_writedata  <= {DATA_WIDTH{1'b0}};
            r_byteenable <= 4'b0000;
            r_i_readdata <= {DATA_WIDTH{1'b0}};
            r_d_readdata <= {DATA_WIDTH{1'b0}};
            r_i_wait     <= 1'b1;
            r_d_wait     <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_last_d     <= w_last_d_nxt;
            r_grant      <= w_grant_nxt;
            r_address    <= w_address_nxt;
            r_read       <= w_read_nxt;
            r_write      <= w_write_nxt;
            r_writedata  <= w_writedata_nxt;
            r_byteenable <= w_byteenable_nxt;
            r_i_readdata <= w_i_readdata_nxt;
            r_d_readdata <= w_d_readdata_nxt;
            r_i_wait     <= w_i_wait_nxt;
            r_d_wait     <= w_d_wait_nxt;
        end
    end

    assign address       = r_address;
    assign read          = r_read;
    assign write         = r_write;
    assign writedata     = r_writedata;
    assign byteenable    = r_byteenable;
    assign grant         = r_grant;
    assign i_readdata    = r_i_readdata;
    assign i_waitrequest = r_i_wait;
    assign d_readdata    = r_d_readdata;
    assign d_waitrequest = r_d_wait;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mips_bus_arbiter
//
// Directed bench for mips_bus_arbiter. Instance u_rr runs in round-robin mode
// against a small byte-lane RAM with programmable wait states; instance u_fp
// runs in fixed-priority mode against a zero-wait read-only responder.
// Expected read words are queued when a request is driven and popped when the
// owning master's completion pulse is observed.
// -----------------------------------------------------------------------------
module tb_mips_bus_arbiter;

    logic clk;
    logic reset;

    // ---------------- round-robin instance ----------------
    logic        i_read, d_read, d_write;
    logic [31:0] i_address, d_address, d_writedata;
    logic [3:0]  d_byteenable;
    logic [31:0] i_readdata, d_readdata;
    logic        i_waitrequest, d_waitrequest;
    logic [31:0] address, writedata, readdata;
    logic        read, write, waitrequest;
    logic [3:0]  byteenable;
    logic [1:0]  grant;

    // ---------------- fixed-priority instance ----------------
    logic        i_read_b, d_read_b, d_write_b;
    logic [31:0] i_address_b, d_address_b, d_writedata_b;
    logic [3:0]  d_byteenable_b;
    logic [31:0] i_readdata_b, d_readdata_b;
    logic        i_waitrequest_b, d_waitrequest_b;
    logic [31:0] address_b, writedata_b, readdata_b;
    logic        read_b, write_b;
    logic [3:0]  byteenable_b;
    logic [1:0]  grant_b;

    // bench bookkeeping
    int          errors;
    int          checks;
    logic [31:0] exp_i_q[$];
    logic [31:0] exp_d_q[$];
    int          i_pulses, d_pulses;

    // RAM model for the round-robin instance
    logic [31:0] mem0 [0:15];
    logic [2:0]  wcnt;
    logic [2:0]  wait_n;
    logic        mem_init;

    mips_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ROUND_ROBIN(1)) u_rr (
        .clk(clk), .reset(reset),
        .i_read(i_read), .i_address(i_address),
        .i_readdata(i_readdata), .i_waitrequest(i_waitrequest),
        .d_read(d_read), .d_write(d_write), .d_address(d_address),
        .d_writedata(d_writedata), .d_byteenable(d_byteenable),
        .d_readdata(d_readdata), .d_waitrequest(d_waitrequest),
        .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable),
        .readdata(readdata), .waitrequest(waitrequest), .grant(grant)
    );

    mips_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ROUND_ROBIN(0)) u_fp (
        .clk(clk), .reset(reset),
        .i_read(i_read_b), .i_address(i_address_b),
        .i_readdata(i_readdata_b), .i_waitrequest(i_waitrequest_b),
        .d_read(d_read_b), .d_write(d_write_b), .d_address(d_address_b),
        .d_writedata(d_writedata_b), .d_byteenable(d_byteenable_b),
        .d_readdata(d_readdata_b), .d_waitrequest(d_waitrequest_b),
        .address(address_b), .read(read_b), .write(write_b),
        .writedata(writedata_b), .byteenable(byteenable_b),
        .readdata(readdata_b), .waitrequest(1'b0), .grant(grant_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int k);
        if (k == 0)      return 32'h24022222;
        else if (k == 4) return 32'hAAAA5555;
        else             return 32'h5A000000 | k;
    endfunction

    // bus stalls for wait_n cycles on each strobe, then accepts it
    assign waitrequest = (read | write) && (wcnt != wait_n);

    always @(posedge clk) begin
        if (mem_init) begin
            for (int k = 0; k < 16; k++) mem0[k] <= init_word(k);
        end else if (write && !waitrequest) begin
            for (int b = 0; b < 4; b++)
                if (byteenable[b]) mem0[address[5:2]][8*b +: 8] <= writedata[8*b +: 8];
        end
        if (read && !waitrequest) readdata <= mem0[address[5:2]];
        if ((read | write) && waitrequest) wcnt <= wcnt + 3'd1;
        else                               wcnt <= 3'd0;
    end

    // fixed-priority responder: one-cycle read latency, never stalls
    always @(posedge clk) begin
        if (read_b) readdata_b <= {16'hD0D0, address_b[15:0]};
    end

    always @(posedge clk) begin
        if (!i_waitrequest) i_pulses <= i_pulses + 1;
        if (!d_waitrequest) d_pulses <= d_pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // pop the oldest expected word for a master and compare
    task automatic sb_check(input bit is_d, input logic [31:0] obs, input string tag);
        logic [31:0] exp;
        if (is_d ? (exp_d_q.size() == 0) : (exp_i_q.size() == 0)) begin
            checks++;
            errors++;
            $error("FAIL %s: observed=%h expected=<none queued>", tag, obs);
        end else begin
            exp = is_d ? exp_d_q.pop_front() : exp_i_q.pop_front();
            check(tag, obs, exp);
        end
    endtask

    // single read from a master (called at a negedge), bounded wait
    task automatic do_read(input bit is_d, input logic [31:0] addr, input logic [31:0] exp,
                           input int exp_lat, input string tag);
        int lat;
        bit done;
        if (is_d) begin
            d_read = 1'b1; d_address = addr; exp_d_q.push_back(exp);
        end else begin
            i_read = 1'b1; i_address = addr; exp_i_q.push_back(exp);
        end
        lat = 0;
        done = 1'b0;
        while (!done && lat < 50) begin
            @(negedge clk);
            lat++;
            if (is_d ? !d_waitrequest : !i_waitrequest) done = 1'b1;
        end
        check({tag, "_latency"}, lat, exp_lat);
        if (done) sb_check(is_d, is_d ? d_readdata : i_readdata, {tag, "_data"});
        i_read = 1'b0;
        d_read = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ip0, dp0, ncomp, gidx, cyc, icnt, dcnt;
        logic [1:0] prev_grant;
        logic [1:0] exp_grant [4];

        errors = 0; checks = 0; i_pulses = 0; d_pulses = 0;
        reset = 1'b0; mem_init = 1'b1; wait_n = 3'd0;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        i_address = 32'h0; d_address = 32'h0; d_writedata = 32'h0; d_byteenable = 4'h0;
        i_read_b = 1'b0; d_read_b = 1'b0; d_write_b = 1'b0;
        i_address_b = 32'h0; d_address_b = 32'h0; d_writedata_b = 32'h0; d_byteenable_b = 4'h0;

        // ---- reset values ----
        repeat (3) @(negedge clk);
        check("rst_strobes", {30'd0, read, write}, 32'd0);
        check("rst_address", address, 32'd0);
        check("rst_writedata", writedata, 32'd0);
        check("rst_byteenable", {28'd0, byteenable}, 32'd0);
        check("rst_grant", {30'd0, grant}, 32'd0);
        check("rst_waits", {30'd0, i_waitrequest, d_waitrequest}, 32'd3);
        check("rst_readdata", i_readdata | d_readdata, 32'd0);
        check("rst_grant_b", {30'd0, grant_b}, 32'd0);

        mem_init = 1'b0;
        reset = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("idle", {26'd0, read, write, grant, i_waitrequest, d_waitrequest}, 32'd3);
        end

        // ---- I read, no wait states, cycle by cycle ----
        i_read = 1'b1; i_address = 32'hBFC00000; exp_i_q.push_back(32'h24022222);
        @(negedge clk);
        check("iread_c1_strobes", {30'd0, read, write}, 32'd2);
        check("iread_c1_be", {28'd0, byteenable}, 32'hF);
        check("iread_c1_addr", address, 32'hBFC00000);
        check("iread_c1_grant", {30'd0, grant}, 32'd1);
        check("iread_c1_iwait", {31'd0, i_waitrequest}, 32'd1);
        @(negedge clk);
        check("iread_c2_read", {31'd0, read}, 32'd0);
        check("iread_c2_iwait", {31'd0, i_waitrequest}, 32'd1);
        @(negedge clk);
        check("iread_c3_iwait", {31'd0, i_waitrequest}, 32'd0);
        check("iread_c3_dwait", {31'd0, d_waitrequest}, 32'd1);
        sb_check(1'b0, i_readdata, "iread_c3_data");
        i_read = 1'b0;
        @(negedge clk);
        check("iread_c4_iwait", {31'd0, i_waitrequest}, 32'd1);
        check("iread_c4_grant", {30'd0, grant}, 32'd0);

        // ---- D write, three wait states ----
        wait_n = 3'd3; dp0 = d_pulses;
        d_write = 1'b1; d_address = 32'hBFC00010; d_writedata = 32'h00002222; d_byteenable = 4'b0011;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check("dwr_strobes", {30'd0, read, write}, 32'd1);
            check("dwr_addr", address, 32'hBFC00010);
            check("dwr_data", writedata, 32'h00002222);
            check("dwr_be", {28'd0, byteenable}, 32'h3);
            check("dwr_grant", {30'd0, grant}, 32'd2);
            check("dwr_dwait", {31'd0, d_waitrequest}, 32'd1);
        end
        @(negedge clk);
        check("dwr_done_write", {31'd0, write}, 32'd0);
        check("dwr_done_dwait", {31'd0, d_waitrequest}, 32'd0);
        d_write = 1'b0;
        @(negedge clk);
        check("dwr_after_dwait", {31'd0, d_waitrequest}, 32'd1);
        check("dwr_ram", mem0[4], 32'hAAAA2222);
        repeat (3) @(negedge clk);
        check("dwr_pulses", d_pulses - dp0, 32'd1);
        wait_n = 3'd0;

        // ---- read back via D, then an I read so I owns last_grant ----
        do_read(1'b1, 32'hBFC00010, 32'hAAAA2222, 3, "dread");
        do_read(1'b0, 32'hBFC00000, 32'h24022222, 3, "iread2");

        // ---- round robin under continuous contention ----
        exp_grant[0] = 2'b10; exp_grant[1] = 2'b01; exp_grant[2] = 2'b10; exp_grant[3] = 2'b01;
        ip0 = i_pulses; dp0 = d_pulses;
        i_read = 1'b1; i_address = 32'hBFC00000;
        d_read = 1'b1; d_address = 32'hBFC00010;
        for (int k = 0; k < 2; k++) begin
            exp_i_q.push_back(32'h24022222);
            exp_d_q.push_back(32'hAAAA2222);
        end
        ncomp = 0; gidx = 0; cyc = 0; prev_grant = 2'b00;
        while (ncomp < 4 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (grant != 2'b00 && prev_grant == 2'b00) begin
                if (gidx < 4) check("rr_grant_order", {30'd0, grant}, {30'd0, exp_grant[gidx]});
                gidx++;
            end
            prev_grant = grant;
            if (!i_waitrequest) begin
                check("rr_i_owner", {30'd0, grant}, 32'd1);
                sb_check(1'b0, i_readdata, "rr_i_data");
                ncomp++;
            end
            if (!d_waitrequest) begin
                check("rr_d_owner", {30'd0, grant}, 32'd2);
                sb_check(1'b1, d_readdata, "rr_d_data");
                ncomp++;
            end
            if (ncomp >= 4) begin
                i_read = 1'b0;
                d_read = 1'b0;
            end
        end
        i_read = 1'b0; d_read = 1'b0;
        check("rr_completions", ncomp, 32'd4);
        check("rr_grants", gidx, 32'd4);
        repeat (3) @(negedge clk);
        check("rr_i_pulses", i_pulses - ip0, 32'd2);
        check("rr_d_pulses", d_pulses - dp0, 32'd2);
        check("rr_idle_grant", {30'd0, grant}, 32'd0);

        // ---- fixed priority: D served every time ----
        i_read_b = 1'b1; i_address_b = 32'h00000100;
        d_read_b = 1'b1; d_address_b = 32'h00000200; d_byteenable_b = 4'hF;
        icnt = 0; dcnt = 0; cyc = 0;
        while (dcnt < 3 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (grant_b != 2'b00) check("fp_grant", {30'd0, grant_b}, 32'd2);
            if (read_b) check("fp_bus", {27'd0, write_b, byteenable_b}, 32'hF);
            if (!i_waitrequest_b) icnt++;
            if (!d_waitrequest_b) begin
                check("fp_d_data", d_readdata_b, 32'hD0D00200);
                dcnt++;
            end
        end
        i_read_b = 1'b0; d_read_b = 1'b0;
        check("fp_d_count", dcnt, 32'd3);
        check("fp_i_count", icnt, 32'd0);
        check("fp_i_readdata", i_readdata_b, 32'd0);
        check("fp_writedata", writedata_b, 32'd0);
        repeat (3) @(negedge clk);

        // ---- reset during ISSUE of a read ----
        wait_n = 3'd5; ip0 = i_pulses;
        i_read = 1'b1; i_address = 32'hBFC00000;
        @(negedge clk);
        check("abort_c1_read", {31'd0, read}, 32'd1);
        @(negedge clk);
        check("abort_c2_read", {31'd0, read}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("abort_read_async", {31'd0, read}, 32'd0);
        check("abort_grant_async", {30'd0, grant}, 32'd0);
        check("abort_iwait", {31'd0, i_waitrequest}, 32'd1);
        i_read = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        wait_n = 3'd0;
        repeat (4) @(negedge clk);
        check("abort_no_pulse", i_pulses - ip0, 32'd0);
        do_read(1'b0, 32'hBFC00000, 32'h24022222, 3, "after_abort");
        check("sb_empty", exp_i_q.size() + exp_d_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
